noc_inject_arbiter: RTL and testbench
=====================================

// Module: noc_inject_arbiter
// PURPOSE
//  Clocked injection scheduler for the NoC tree. It shares one router input port
//  among N_SRC packet sources (data-generator style, 14-bit packets).
//  - Round-robin arbitration between sources.
//  - Per-source injection gap: a minimum idle spacing per source, the clocked
//    equivalent of the generator forward delay.
//  - One-entry output register with valid/ready handshake.
//  - Count of delivered packets.
//  It sits between the traffic sources and the leaf router input.
// PARAMETERS
//  N_SRC         4   number of requesters (>=2)
//  WIDTH_packet  14  packet width, bits
//  GAP           2   idle cycles a source must wait after being granted (0 = none)
//  CNT_W         16  width of the sent-packet counter
// PORTS
//  clk        in   1                    clock; all state updates on rising edge
//  reset      in   1                    asynchronous, active-high reset
//  enable     in   1                    1 = new grants allowed; 0 = hold off injection
//  in_valid   in   N_SRC                source i presents a packet
//  in_data    in   N_SRC*WIDTH_packet   packet of source i, in slice [i*W +: W]
//  in_ready   out  N_SRC                one-hot grant; source i's packet accepted this cycle
//  out_valid  out  1                    output register holds a packet
//  out_data   out  WIDTH_packet         packet toward router
//  out_ready  in   1                    router accepts out_data this cycle
//  sent_count out  CNT_W                packets delivered (out_valid & out_ready)
// BEHAVIOUR
//  Reset (async, any time):
//   - out_valid=0, out_data=0, sent_count=0, all gap counters=0.
//   - last_grant=N_SRC-1, so src0 has top priority.
//   - Any packet held in the output register is dropped.
//   - in_ready is all 0 while reset is high.
//  Output stage FSM (EMPTY/FULL):
//   - load_ok = !out_valid | out_ready.
//   - EMPTY->FULL on grant.
//   - FULL->EMPTY on out_ready with no grant.
//   - FULL->FULL on out_ready with a grant (drain and load in the same cycle).
//   - FULL holds while out_ready=0; out_data stays stable.
//  Eligibility: elig[i] = in_valid[i] & (gap_cnt[i]==0).
//  Grant:
//   - When enable & load_ok & |elig, grant the first eligible index searching
//     from last_grant+1 upward, modulo N_SRC.
//   - in_ready = that one-hot grant, combinational. It may depend on in_valid
//     but never on an in_ready.
//   - Otherwise in_ready=0.
//  On grant of source g:
//   - out_data<=in_data[g], out_valid<=1, last_grant<=g.
//   - gap_cnt[g]<=GAP.
//  Gap counters:
//   - Every non-zero gap_cnt decrements by 1 each cycle.
//   - The granted source's counter is loaded with GAP rather than decremented.
//   - With GAP=k, a continuously valid sole source is granted every k+1 cycles.
//  last_grant changes only on a grant.
//  Latency and throughput:
//   - Accept in cycle t -> out_valid from edge t+1.
//   - Throughput 1 packet/cycle when out_ready=1 and eligible sources exist.
//  enable=0:
//   - No new grants.
//   - A held packet still drains on out_ready.
//   - Gap counters keep decrementing.
//  sent_count: +1 on each out_valid & out_ready; wraps 2^CNT_W-1 -> 0 with no flag.
//  Simultaneous grant and drain in one cycle is legal; sent_count still increments.
//  Sources must hold in_valid/in_data until in_ready; withdrawing is tolerated
//  (no grant is issued without in_valid).
// STRUCTURE
//  Package noc_inject_pkg:
//   - localparam WIDTH_packet=14.
//   - typedef logic [WIDTH_packet-1:0] packet_t.
//   - typedef enum logic {EMPTY, FULL} out_state_t.
//  Sub-module rr_arbiter #(N):
//   - Inputs: req[N], last_grant, en.
//   - Output: one-hot gnt.
//   - Purely combinational; the pointer register lives in the parent.
//  The parent holds the gap counters, output register, FSM and sent_count.
// TESTING
//  1 Reset mid-traffic (out_valid=1, gap counters non-zero), reset=1 between
//    edges -> out_valid=0, sent_count=0 immediately; after release with all
//    sources valid, src0 is granted first.
//  2 GAP=0, 4 sources valid constantly, in_data=16'hA0+i, out_ready=1
//    -> grants 0,1,2,3,0,...; out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
//  3 GAP=2, only src1 valid constantly -> in_ready[1] high every 3rd cycle;
//    sent_count=4 after 12 cycles.
//  4 out_ready=0 while FULL with 0x1234, sources valid -> in_ready=0, out_data
//    stable for 5 cycles; out_ready=1 -> 0x1234 delivered and next packet
//    loaded in the same cycle.
//  5 enable=0 with a packet held -> packet drains, then out_valid=0 and
//    in_ready=0 while enable=0; enable=1 -> granting resumes at last_grant+1.
//  6 Preload traffic until sent_count=16'hFFFF, deliver one more -> sent_count=0.

Source files
------------

// File: rtl/noc_inject_pkg.sv
// Shared types for the NoC injection scheduler.
// Packet width and output-stage state encoding.
package noc_inject_pkg;

  localparam int WIDTH_packet = 14;

  typedef logic [WIDTH_packet-1:0] packet_t;

  typedef enum logic {
    EMPTY,
    FULL
  } out_state_t;

endpackage

// File: rtl/noc_inject_rr_arbiter.sv
// Combinational round-robin picker.
// Searches from lastGrant+1 upward; the pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] lastGrant,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;
  int            pos;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(lastGrant) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Injection scheduler: round-robin over N_SRC sources with per-source
// injection gap, one-entry output register and delivered-packet counter.
module noc_inject_arbiter #(
  parameter int N_SRC        = 4,
  parameter int WIDTH_packet = noc_inject_pkg::WIDTH_packet,
  parameter int GAP          = 2,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [N_SRC-1:0]              in_valid,
  input  logic [N_SRC*WIDTH_packet-1:0] in_data,
  output logic [N_SRC-1:0]              in_ready,
  output logic                          out_valid,
  output logic [WIDTH_packet-1:0]       out_data,
  input  logic                          out_ready,
  output logic [CNT_W-1:0]              sent_count
);

  import noc_inject_pkg::*;

  localparam int PW = $clog2(N_SRC);
  localparam int GW = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_V = GW'(GAP);

  out_state_t              state;
  logic [PW-1:0]           lastGrant;
  logic [GW-1:0]           gapCnt [N_SRC];
  logic [N_SRC-1:0]        elig;
  logic [N_SRC-1:0]        gnt;
  logic                    loadOk;
  logic                    grant;
  logic [PW-1:0]           gIdx;
  logic [WIDTH_packet-1:0] gData;

  assign out_valid = (state == FULL);
  assign loadOk    = !out_valid || out_ready;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++)
      elig[i] = in_valid[i] && (gapCnt[i] == '0);
  end

  // Reset gates the enable so in_ready is silent while reset is held.
  rr_arbiter #(
    .N(N_SRC)
  ) uArb (
    .req      (elig),
    .lastGrant(lastGrant),
    .en       (enable && loadOk && !reset),
    .gnt      (gnt)
  );

  assign in_ready = gnt;
  assign grant    = |gnt;

  always_comb begin
    gIdx  = '0;
    gData = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        gIdx  = PW'(i);
        gData = in_data[i*WIDTH_packet +: WIDTH_packet];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      out_data   <= '0;
      lastGrant  <= PW'(N_SRC - 1);
      sent_count <= '0;
      for (int i = 0; i < N_SRC; i++)
        gapCnt[i] <= '0;
    end else begin
      if (out_valid && out_ready)
        sent_count <= sent_count + 1'b1;
      unique case (state)
        EMPTY: if (grant) state <= FULL;
        FULL:  if (out_ready && !grant) state <= EMPTY;
      endcase
      if (grant) begin
        out_data  <= gData;
        lastGrant <= gIdx;
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (gnt[i])
          gapCnt[i] <= GAP_V;
        else if (gapCnt[i] != '0)
          gapCnt[i] <= gapCnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter.
// dut0 runs with GAP=0, dut2 with GAP=2; both share the stimulus.
module tb_noc_inject_arbiter;

  import noc_inject_pkg::*;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int CW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic           out_ready;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;

  logic [N-1:0]  rdy0, rdy2;
  logic          ov0, ov2;
  packet_t       od0, od2;
  logic [CW-1:0] sc0, sc2;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  noc_inject_arbiter #(
    .N_SRC(N), .WIDTH_packet(W), .GAP(0), .CNT_W(CW)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
    .sent_count(sc0)
  );

  noc_inject_arbiter #(
    .N_SRC(N), .WIDTH_packet(W), .GAP(2), .CNT_W(CW)
  ) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
    .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
    .sent_count(sc2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setData(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    for (int i = 0; i < N; i++) setData(i, W'(32'hA0 + i));
    #1;
    chk("rst.ov", 32'(ov0), 32'd0);
    chk("rst.sc", 32'(sc0), 32'd0);
    chk("rst.rdy", 32'(rdy0), 32'd0);
    step();
    step();

    // round robin, GAP=0, all sources valid
    reset     = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b1;
    in_valid  = '1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr.rdy", 32'(rdy0), 32'(1 << k));
      step();
      chk("rr.data", 32'(od0), 32'hA0 + k);
      chk("rr.ov", 32'(ov0), 32'd1);
    end
    chk("rr.sc", 32'(sc0), 32'd3);

    // reset mid-traffic
    chk("mid.ovpre", 32'(ov2), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid.ov", 32'(ov2), 32'd0);
    chk("mid.sc", 32'(sc2), 32'd0);
    chk("mid.rdy", 32'(rdy2), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("mid.first", 32'(rdy2), 32'd1);

    // GAP=2, only src1 valid
    in_valid = 4'b0010;
    #1;
    for (int c = 0; c < 12; c++) begin
      chk("gap.rdy", 32'(rdy2), (c % 3 == 0) ? 32'd2 : 32'd0);
      step();
    end
    chk("gap.sc", 32'(sc2), 32'd4);

    // backpressure holds 0x1234
    reset = 1'b1;
    step();
    reset     = 1'b0;
    setData(0, 14'h1234);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    chk("bp.rdy0", 32'(rdy0), 32'd1);
    step();
    in_valid = '1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp.data", 32'(od0), 32'h1234);
      chk("bp.rdy", 32'(rdy0), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.regrant", 32'(rdy0), 32'd2);
    step();
    chk("bp.sc", 32'(sc0), 32'd1);
    chk("bp.next", 32'(od0), 32'hA1);

    // enable=0 drains and blocks
    enable = 1'b0;
    #1;
    chk("en.rdy", 32'(rdy0), 32'd0);
    step();
    chk("en.sc", 32'(sc0), 32'd2);
    chk("en.ov", 32'(ov0), 32'd0);
    chk("en.rdy2", 32'(rdy0), 32'd0);
    step();
    chk("en.ov2", 32'(ov0), 32'd0);
    enable = 1'b1;
    #1;
    chk("en.resume", 32'(rdy0), 32'd4);
    step();
    chk("en.data", 32'(od0), 32'hA2);

    // counter wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (65536) step();
    chk("wrap.max", 32'(sc0), 32'hFFFF);
    step();
    chk("wrap.zero", 32'(sc0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
